uart_cmd_link: RTL and testbench

//  Command sender feeding uart_tx and consuming uart_rx. Takes a 4-bit command code from the

---
 rtl/uart_cmd_link.sv | 108 ++++++++++
 tb/tb_uart_cmd_link.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: sends a Hamming(7,4)-encoded command byte through uart_tx and waits for an ACK byte from uart_rx, retrying on timeout.
// Ports: clk/reset (sync, active-high); cmd_code/cmd_valid/cmd_ready command handshake;
//   data_to_tx/start_tx/tx_busy to uart_tx; data_received/rx_done/parity_error from uart_rx;
//   done/fail one-cycle result pulses; retries = retransmissions used by the current/last command.
module uart_cmd_link #(
   parameter logic [7:0] ACK_BYTE    = 8'h3C,
   parameter int         ACK_TIMEOUT = 48000,
   parameter int         MAX_RETRIES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cmd_code,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] data_to_tx,
   output logic       start_tx,
   input  logic       tx_busy,
   input  logic [7:0] data_received,
   input  logic       rx_done,
   input  logic       parity_error,
   output logic       done,
   output logic       fail,
   output logic [3:0] retries
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_WAIT_ACK, S_DONE, S_FAIL} state_t;
   state_t state_q, state_d;
   logic [3:0] cmd_q, cmd_d, retries_q, retries_d;
   logic [7:0] data_q, data_d;
   logic [TW-1:0] timer_q, timer_d;
   logic ready_q, ready_d, start_q, start_d, done_q, done_d, fail_q, fail_d;
   logic ack, expired;
   function automatic logic [7:0] hamming(input logic [3:0] d);
      return {1'b1, d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
   endfunction
   assign ack     = rx_done && !parity_error && data_received == ACK_BYTE;
   assign expired = timer_q == TW'(ACK_TIMEOUT - 1);
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      retries_d = retries_q;
      data_d    = data_q;
      timer_d   = timer_q;
      case (state_q)
         S_IDLE:    if (cmd_valid) begin
                       cmd_d     = cmd_code;
                       retries_d = '0;
                       state_d   = S_LOAD;
                    end
         S_LOAD:    begin
                       data_d  = hamming(cmd_q);
                       state_d = S_START;
                    end
         S_START:   state_d = S_WAIT_HI;
         S_WAIT_HI: if (tx_busy) state_d = S_WAIT_LO;
         S_WAIT_LO: if (!tx_busy) begin
                       timer_d = '0;
                       state_d = S_WAIT_ACK;
                    end
         S_WAIT_ACK: begin
                       timer_d = timer_q + 1'b1;
                       // an ACK arriving on the expiry cycle takes priority over a retry
                       if (ack) state_d = S_DONE;
                       else if (expired) begin
                          if (retries_q < 4'(MAX_RETRIES)) begin
                             retries_d = retries_q + 1'b1;
                             state_d   = S_START;
                          end else state_d = S_FAIL;
                       end
                    end
         default:   state_d = S_IDLE;
      endcase
      // outputs are registered from the next state so they line up with the state they describe
      ready_d = state_d == S_IDLE;
      start_d = state_d == S_START;
      done_d  = state_d == S_DONE;
      fail_d  = state_d == S_FAIL;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         retries_q <= '0;
         data_q    <= '0;
         timer_q   <= '0;
         ready_q   <= 1'b1;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         retries_q <= retries_d;
         data_q    <= data_d;
         timer_q   <= timer_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         done_q    <= done_d;
         fail_q    <= fail_d;
      end
   end
   assign cmd_ready  = ready_q;
   assign data_to_tx = data_q;
   assign start_tx   = start_q;
   assign done       = done_q;
   assign fail       = fail_q;
   assign retries    = retries_q;
endmodule

// File: tb/tb_uart_cmd_link.sv
// tb_uart_cmd_link: directed and random checks of uart_cmd_link against a transaction-level model.
module tb_uart_cmd_link;
   localparam int T  = 40;
   localparam int MR = 3;
   localparam int BOUND = 300;
   logic clk, reset, cmd_valid, cmd_ready, start_tx, tx_busy, rx_done, parity_error, done, fail;
   logic [3:0] cmd_code, retries;
   logic [7:0] data_to_tx, data_received;
   int n_chk = 0, n_err = 0, cyc = 0;
   int n_start = 0, n_done = 0, n_fail = 0;
   logic [7:0] last_data = 8'h00;
   logic e_ready, e_start, e_done, e_fail;
   logic [7:0] e_data;
   logic [3:0] e_ret;
   bit rs, auto_en = 0;

   uart_cmd_link #(.ACK_BYTE(8'h3C), .ACK_TIMEOUT(T), .MAX_RETRIES(MR)) dut (
      .clk(clk), .reset(reset), .cmd_code(cmd_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .data_to_tx(data_to_tx), .start_tx(start_tx), .tx_busy(tx_busy), .data_received(data_received),
      .rx_done(rx_done), .parity_error(parity_error), .done(done), .fail(fail), .retries(retries));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Hamming(7,4) by position: data sits at non-power-of-two positions, parity k covers positions with bit k set
   function automatic logic [7:0] ref_enc(input logic [3:0] d);
      logic [7:0] w;
      logic p;
      int pos [4];
      pos = '{3, 5, 6, 7};
      w = 8'h80;
      for (int i = 0; i < 4; i++) if (d[i]) w[pos[i]-1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         p = 1'b0;
         for (int q = 1; q < 8; q++) if ((q & (1 << k)) != 0 && q != (1 << k)) p = p ^ w[q-1];
         w[(1 << k) - 1] = p;
      end
      return w;
   endfunction

   task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
      end
   endtask

   // uart_tx stand-in: every start_tx request becomes one busy frame after a short random delay
   int pend = 0, phase = 0, dly = 0, blen = 0;
   initial tx_busy = 0;
   always @(negedge clk) begin
      if (start_tx === 1'b1) pend++;
      if (phase == 0 && pend > 0) begin
         pend--;
         dly = $urandom_range(1, 3);
         blen = $urandom_range(4, 12);
         phase = 1;
      end else if (phase == 1) begin
         dly--;
         if (dly == 0) begin tx_busy = 1; phase = 2; end
      end else if (phase == 2) begin
         blen--;
         if (blen == 0) begin tx_busy = 0; phase = 0; end
      end
   end

   // random-phase remote: after each busy fall reply with ACK, garbage, parity-errored ACK or nothing
   initial begin
      bit bp;
      int k, kind;
      bp = 0;
      forever begin
         @(posedge clk);
         if (auto_en && bp && !tx_busy) begin
            k = $urandom_range(0, T + 4);
            kind = $urandom_range(0, 3);
            repeat (k) @(posedge clk);
            if (kind != 3) begin
               @(negedge clk);
               rx_done = 1;
               data_received = (kind == 1) ? 8'($urandom_range(0, 255)) : 8'h3C;
               parity_error = (kind == 2);
               @(negedge clk);
               rx_done = 0;
               parity_error = 0;
            end
         end
         bp = tx_busy;
      end
   end

   // transaction-level model: follows one command from accept to done/fail, edge by edge
   task automatic rst_exp();
      e_ready = 1; e_data = 0; e_start = 0; e_done = 0; e_fail = 0; e_ret = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      rs = reset;
      if (rs) rst_exp();
   endtask

   task automatic model_err(input string nm);
      n_chk++;
      n_err++;
      $display("FAIL %s: no tx_busy edge within %0d cycles", nm, BOUND);
   endtask

   task automatic model_cmd();
      logic [3:0] code;
      int n;
      tick(); if (rs) return;
      if (!cmd_valid) return;
      code = cmd_code;
      e_ready = 0;
      e_ret = 0;
      tick(); if (rs) return;
      e_data = ref_enc(code);
      e_start = 1;
      forever begin
         tick(); if (rs) return;
         e_start = 0;
         n = 0;
         forever begin
            tick(); if (rs) return;
            if (tx_busy) break;
            if (++n > BOUND) begin model_err("model_wait_busy_hi"); return; end
         end
         n = 0;
         forever begin
            tick(); if (rs) return;
            if (!tx_busy) break;
            if (++n > BOUND) begin model_err("model_wait_busy_lo"); return; end
         end
         for (int t = 0; t < T; t++) begin
            tick(); if (rs) return;
            if (rx_done && !parity_error && data_received == 8'h3C) begin
               e_done = 1;
               tick(); if (rs) return;
               e_done = 0;
               e_ready = 1;
               return;
            end
         end
         if (int'(e_ret) < MR) begin
            e_ret = e_ret + 1;
            e_start = 1;
         end else begin
            e_fail = 1;
            tick(); if (rs) return;
            e_fail = 0;
            e_ready = 1;
            return;
         end
      end
   endtask

   initial begin
      rst_exp();
      forever model_cmd();
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("cmd_ready", {7'b0, cmd_ready}, {7'b0, e_ready});
         chk("start_tx", {7'b0, start_tx}, {7'b0, e_start});
         chk("done", {7'b0, done}, {7'b0, e_done});
         chk("fail", {7'b0, fail}, {7'b0, e_fail});
         chk("retries", {4'b0, retries}, {4'b0, e_ret});
         chk("data_to_tx", data_to_tx, e_data);
         if (start_tx === 1'b1) begin n_start++; last_data = data_to_tx; end
         if (done === 1'b1) n_done++;
         if (fail === 1'b1) n_fail++;
      end
   end

   task automatic send(input logic [3:0] c);
      @(negedge clk);
      cmd_valid = 1;
      cmd_code = c;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1) begin
         if (++n > 2000) begin
            n_chk++; n_err++;
            $display("FAIL %s: cmd_ready not back within 2000 cycles", nm);
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic wait_fall();
      int n;
      n = 0;
      do @(posedge clk); while (tx_busy !== 1'b1 && ++n < BOUND);
      n = 0;
      do @(posedge clk); while (tx_busy !== 1'b0 && ++n < BOUND);
      if (n >= BOUND) begin
         n_chk++; n_err++;
         $display("FAIL wait_fall: tx_busy did not fall within %0d cycles", BOUND);
      end
   endtask

   // drive an rx strobe that the DUT samples while its ack timer holds k (counted from the busy-fall edge)
   task automatic rx_at(input int k, input logic [7:0] d, input logic pe);
      repeat (k) @(posedge clk);
      @(negedge clk);
      rx_done = 1;
      data_received = d;
      parity_error = pe;
      @(negedge clk);
      rx_done = 0;
      parity_error = 0;
   endtask

   initial begin
      int s0, d0, f0;
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0, f0;
      reset = 1; cmd_valid = 0; cmd_code = 0; rx_done = 0; parity_error = 0; data_received = 0;
      repeat (3) @(negedge clk);
      chk("reset_ready", {7'b0, cmd_ready}, 8'h01);
      chk("reset_data", data_to_tx, 8'h00);
      reset = 0;
      chk("ref_enc_6", ref_enc(4'h6), 8'hB3);
      chk("ref_enc_D", ref_enc(4'hD), 8'hE6);
      // 1: single command acknowledged
      s0 = n_start; d0 = n_done;
      send(4'h6);
      wait_fall();
      rx_at(20, 8'h3C, 0);
      wait_idle("t1");
      chk("t1_data", last_data, 8'hB3);
      chk("t1_starts", 8'(n_start - s0), 8'd1);
      chk("t1_done", 8'(n_done - d0), 8'd1);
      chk("t1_retries", {4'b0, retries}, 8'd0);
      // 2: no reply, retries exhausted
      s0 = n_start; f0 = n_fail; d0 = n_done;
      send(4'hD);
      wait_idle("t2");
      chk("t2_data", last_data, 8'hE6);
      chk("t2_starts", 8'(n_start - s0), 8'd4);
      chk("t2_fail", 8'(n_fail - f0), 8'd1);
      chk("t2_done", 8'(n_done - d0), 8'd0);
      chk("t2_retries", {4'b0, retries}, 8'd3);
      repeat (5) @(negedge clk);
      chk("t2_retries_hold", {4'b0, retries}, 8'd3);
      // 3: parity-errored ACK and wrong byte are ignored
      s0 = n_start; d0 = n_done;
      send(4'h6);
      wait_fall();
      rx_at(3, 8'h3C, 1);
      rx_at(2, 8'h55, 0);
      rx_at(4, 8'h3C, 0);
      wait_idle("t3");
      chk("t3_starts", 8'(n_start - s0), 8'd1);
      chk("t3_done", 8'(n_done - d0), 8'd1);
      // 4: ACK on the expiry cycle wins
      s0 = n_start; d0 = n_done; f0 = n_fail;
      send(4'h9);
      wait_fall();
      rx_at(T - 1, 8'h3C, 0);
      wait_idle("t4");
      chk("t4_starts", 8'(n_start - s0), 8'd1);
      chk("t4_done", 8'(n_done - d0), 8'd1);
      chk("t4_retries", {4'b0, retries}, 8'd0);
      // 5: reset during WAIT_ACK
      d0 = n_done; f0 = n_fail;
      send(4'h6);
      wait_fall();
      repeat (5) @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("t5_ready", {7'b0, cmd_ready}, 8'h01);
      reset = 0;
      repeat (T + 20) @(negedge clk);
      chk("t5_no_done", 8'(n_done - d0), 8'd0);
      chk("t5_no_fail", 8'(n_fail - f0), 8'd0);
      send(4'hD);
      wait_fall();
      rx_at(5, 8'h3C, 0);
      wait_idle("t5b");
      chk("t5_done_after", 8'(n_done - d0), 8'd1);
      // 6: stray ACK while idle is not carried over
      s0 = n_start; d0 = n_done; f0 = n_fail;
      rx_at(0, 8'h3C, 0);
      repeat (2) @(negedge clk);
      send(4'h6);
      wait_idle("t6");
      chk("t6_done", 8'(n_done - d0), 8'd0);
      chk("t6_fail", 8'(n_fail - f0), 8'd1);
      chk("t6_starts", 8'(n_start - s0), 8'd4);
      // random phase: commands, replies and rare resets all from $urandom
      auto_en = 1;
      repeat (3000) begin
         @(negedge clk);
         cmd_valid = ($urandom_range(0, 5) == 0);
         cmd_code = 4'($urandom_range(0, 15));
         reset = ($urandom_range(0, 599) == 0);
      end
      cmd_valid = 0;
      reset = 0;
      auto_en = 0;
      repeat (T + 60) @(negedge clk);
      wait_idle("rand_end");
      repeat (2 * T) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
